// File: rtl/deadlock_trace_unit_if.sv
// rtl/deadlock_trace_unit_if.sv - signal bundle between the deadlock trace unit and its monitor
interface deadlock_trace_unit_if #(
    parameter int PROC_NUM = 4,
    parameter int IDX_W    = 2,
    parameter int CID_W    = 4
);
    logic [PROC_NUM-1:0]      dl_in_vec;
    logic                     rearm;
    logic                     dl_detect_out;
    logic [PROC_NUM-1:0]      origin;
    logic                     token_clear;
    logic                     trace_valid;
    logic                     trace_ready;
    logic [CID_W+IDX_W+1:0]   trace_data;
    logic [CID_W-1:0]         circle_count;
    logic                     overflow;
    logic                     timeout_err;
    logic                     done;

    modport master (
        input  dl_in_vec, rearm, trace_ready,
        output dl_detect_out, origin, token_clear, trace_valid, trace_data,
               circle_count, overflow, timeout_err, done
    );

    modport slave (
        output dl_in_vec, rearm, trace_ready,
        input  dl_detect_out, origin, token_clear, trace_valid, trace_data,
               circle_count, overflow, timeout_err, done
    );
endinterface

// File: rtl/deadlock_trace_unit.sv
// rtl/deadlock_trace_unit.sv - records deadlock dependence circles as process-index traces in a FIFO
module deadlock_trace_unit #(
    parameter int PROC_NUM    = 4,
    parameter int IDX_W       = 2,
    parameter int CID_W       = 4,
    parameter int TRACE_DEPTH = 16,
    parameter int MAX_CIRCLES = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    deadlock_trace_unit_if.master bus
);
    localparam int DW = CID_W + IDX_W + 2;
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_DETECTED, S_REPORT, S_DONE} state_t;

    state_t              state, state_next;
    logic [PROC_NUM-1:0] dl_detect_reg, detect_next;
    logic [PROC_NUM-1:0] dl_done_reg, done_vec_next;
    logic [PROC_NUM-1:0] origin_reg, origin_next;
    logic [PROC_NUM-1:0] last_vec, last_next;
    logic [TW-1:0]       timer, timer_next;
    logic [CID_W-1:0]    cid, cid_next;
    logic [CID_W-1:0]    circle_count, count_next;
    logic                timeout_reg, tout_next;
    logic                overflow_reg;

    logic [PROC_NUM-1:0] pending, lowest, origin_c;
    logic                hit, token_clear_c;
    logic                push, fifo_clear;
    logic [DW-1:0]       push_data;

    function automatic logic [IDX_W-1:0] hi_idx(input logic [PROC_NUM-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign pending = dl_detect_reg & ~dl_done_reg;
    assign lowest  = pending & (~pending + PROC_NUM'(1));
    assign hit     = |(bus.dl_in_vec & origin_reg);

    always_comb begin
        state_next    = state;
        detect_next   = dl_detect_reg;
        done_vec_next = dl_done_reg;
        origin_next   = origin_reg;
        last_next     = last_vec;
        timer_next    = timer;
        cid_next      = cid;
        count_next    = circle_count;
        tout_next     = timeout_reg;
        origin_c      = '0;
        token_clear_c = 1'b0;
        push          = 1'b0;
        push_data     = '0;
        fifo_clear    = 1'b0;
        case (state)
            S_IDLE: begin
                detect_next = bus.dl_in_vec;
                if (|bus.dl_in_vec) state_next = S_DETECTED;
            end
            S_DETECTED: begin
                if (pending == '0) begin
                    state_next = S_DONE;
                end else begin
                    origin_c    = lowest;
                    origin_next = lowest;
                    last_next   = lowest;
                    timer_next  = '0;
                    cid_next    = cid + CID_W'(1);
                    push        = 1'b1;
                    push_data   = {cid + CID_W'(1), 1'b1, 1'b0, hi_idx(lowest)};
                    state_next  = S_REPORT;
                end
            end
            S_REPORT: begin
                // Any token holder that is part of the detected set has now been visited.
                if (|(bus.dl_in_vec & dl_detect_reg)) done_vec_next = dl_done_reg | bus.dl_in_vec;
                if (hit) begin
                    token_clear_c = 1'b1;
                    push          = 1'b1;
                    push_data     = {cid, 1'b0, 1'b1, hi_idx(origin_reg)};
                    if (int'(circle_count) < MAX_CIRCLES) count_next = circle_count + CID_W'(1);
                    state_next = (int'(circle_count) + 1 == MAX_CIRCLES) ? S_DONE : S_DETECTED;
                end else if (bus.dl_in_vec != '0 && bus.dl_in_vec != last_vec) begin
                    push       = 1'b1;
                    push_data  = {cid, 1'b0, 1'b0, hi_idx(bus.dl_in_vec)};
                    last_next  = bus.dl_in_vec;
                    timer_next = '0;
                end else if (bus.dl_in_vec == '0) begin
                    if (timer == TW'(TIMEOUT - 1)) begin
                        tout_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end else begin
                    timer_next = '0;
                end
            end
            S_DONE: begin
                if (bus.rearm) begin
                    detect_next   = '0;
                    done_vec_next = '0;
                    count_next    = '0;
                    cid_next      = '0;
                    timer_next    = '0;
                    tout_next     = 1'b0;
                    fifo_clear    = 1'b1;
                    state_next    = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            dl_detect_reg <= '0;
            dl_done_reg   <= '0;
            origin_reg    <= '0;
            last_vec      <= '0;
            timer         <= '0;
            cid           <= '0;
            circle_count  <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state         <= state_next;
            dl_detect_reg <= detect_next;
            dl_done_reg   <= done_vec_next;
            origin_reg    <= origin_next;
            last_vec      <= last_next;
            timer         <= timer_next;
            cid           <= cid_next;
            circle_count  <= count_next;
            timeout_reg   <= tout_next;
        end
    end

    // Trace FIFO: extra pointer bit separates full from empty.
    logic [DW-1:0] mem [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, pop, push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.trace_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_reg <= 1'b0;
        end else if (fifo_clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (pop)             rd_ptr       <= rd_ptr + PW'(1);
            if (push_ok)         wr_ptr       <= wr_ptr + PW'(1);
            if (push && !push_ok) overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign bus.dl_detect_out = |dl_detect_reg;
    assign bus.origin        = origin_c;
    assign bus.token_clear   = token_clear_c;
    assign bus.trace_valid   = !empty;
    assign bus.trace_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.circle_count  = circle_count;
    assign bus.overflow      = overflow_reg;
    assign bus.timeout_err   = timeout_reg;
    assign bus.done          = (state == S_DONE);
endmodule

// File: doc/deadlock_trace_unit.md
Name: deadlock_trace_unit

Overview:
Parametrised successor of the per-design deadlock report unit. It tracks deadlock dependence circles across PROC_NUM dataflow processes using the same token-walk protocol (origin / token_clear / dl_in_vec). Instead of printing, it records every circle as a sequence of process indices in a trace FIFO that a bench monitor or a debug AXI-lite shim can read back. It adds a circle limit, a token-walk timeout and a rearm control.

Parameters:
PROC_NUM, 4, number of monitored processes (2..32)
IDX_W, 2, process index width, equals ceil(log2(PROC_NUM))
CID_W, 4, circle id width
TRACE_DEPTH, 16, trace FIFO entries (power of 2, >=2)
MAX_CIRCLES, 8, circles reported before forced DONE (<=2^CID_W-1)
TIMEOUT, 64, idle-token cycles in REPORT before abort (>=2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
dl_in_vec  in  PROC_NUM  per-process deadlock/token-holder flags
rearm  in  1  sync pulse; honoured only in DONE
dl_detect_out  out  1  sticky deadlock indication
origin  out  PROC_NUM  one-hot circle start, valid one cycle in DETECTED
token_clear  out  1  token returned to origin this cycle
trace_valid  out  1  FIFO non-empty
trace_ready  in  1  consumer pop
trace_data  out  CID_W+IDX_W+2  {circle_id, first, last, proc_idx}
circle_count  out  CID_W  completed circles
overflow  out  1  sticky: a trace push was dropped
timeout_err  out  1  sticky: token walk stalled
done  out  1  reporting finished

Behaviour:
- Reset: FSM=IDLE; all registers, FIFO pointers and sticky flags = 0; every output = 0.
- FSM states are IDLE, DETECTED, REPORT and DONE.
- IDLE: dl_detect_reg <= dl_in_vec every cycle. If |dl_in_vec, go to DETECTED.
- dl_detect_out = |dl_detect_reg. Stays high until reset or rearm.
- DETECTED: pending = dl_detect_reg & ~dl_done_reg.
  - If pending==0, go to DONE.
  - Otherwise origin = lowest set bit of pending (combinational, this state only), and on the clock edge: origin_reg<=origin, last_vec<=origin, timer<=0, cid<=cid+1 (cid is 1-based), push {cid+1,1,0,idx(origin)}, go to REPORT.
- REPORT, per cycle, in this priority order:
  - (a) hit = |(dl_in_vec & origin_reg): token_clear=1 combinationally; push {cid,0,1,idx(origin_reg)}; circle_count++.
    - If circle_count+1==MAX_CIRCLES, go to DONE; else go to DETECTED.
  - (b) dl_in_vec!=0 and dl_in_vec!=last_vec: push {cid,0,0,idx(dl_in_vec)}; last_vec<=dl_in_vec; timer<=0.
  - (c) dl_in_vec==0: timer++. When timer reaches TIMEOUT-1, set timeout_err and go to DONE.
  - (d) unchanged nonzero vector: no push; timer<=0.
  - In all REPORT cycles, if |(dl_in_vec & dl_detect_reg), then dl_done_reg |= dl_in_vec.
- idx(v) = highest set bit index of v, and 0 if v==0.
- DONE: done=1. Registers hold; FIFO stays readable. rearm clears dl_detect_reg, dl_done_reg, circle_count, cid, timer, sticky flags and the FIFO, then goes to IDLE. rearm outside DONE is ignored.
- Trace FIFO:
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the entry is dropped, overflow<=1, and FSM flow is unaffected.
  - Pop happens when trace_valid&trace_ready.
  - trace_data is show-ahead: the head entry, combinational from the RAM/registers.
  - Simultaneous push and pop on empty: the entry is readable next cycle.
- Reset asserted mid-REPORT aborts immediately: FIFO content is lost and all outputs return to 0.
- Widths: circle_count saturates at MAX_CIRCLES. cid wraps mod 2^CID_W, but MAX_CIRCLES prevents the wrap.

Test Plan:
- PROC_NUM=4, trace_ready=1. dl_in_vec=0001 for 1 cycle, then 0010, 0100, 0001 -> FIFO gets {1,1,0,0},{1,0,0,1},{1,0,0,2},{1,0,1,0}; token_clear is one pulse on the 0001 cycle; circle_count=1; then DETECTED finds pending=0 and goes to DONE, done=1.
- Two circles: dl_in_vec=1001 in IDLE -> origin=0001 first, then 1000 second. trace_data cid fields are 1 then 2; circle_count=2; done=1.
- Repeated vector 0010 held 5 cycles in REPORT -> exactly one trace entry for proc 1; timer stays 0.
- Token vanishes (dl_in_vec=0) in REPORT for 64 cycles -> timeout_err=1 on cycle 64; done=1; no token_clear.
- trace_ready=0, TRACE_DEPTH=2, 4-process circle -> 2 entries kept, overflow=1, circle_count still reaches 1.
- In DONE, pulse rearm -> dl_detect_out, circle_count, overflow and trace_valid are all 0; FSM in IDLE. A new dl_in_vec=0100 starts cid=1.
- Assert reset mid-REPORT -> all outputs 0 asynchronously.
